mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide execution unit: the consumer side of the decoded `Op` fields `exUnitType == ExUnitType_MulDiv` and `mulDivType`. Sits in the execute stage beside the ALU. It accepts one operation when idle, iterates over a shift-add or restoring-division datapath, and returns a 32-bit result with a one-cycle `done` pulse. The pipeline stalls on `!ready` and can abort the unit with `flush`.

## Interface
- `XLEN`, 32: operand and result width; only 32 is supported.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rstN`  in  1  asynchronous, active-low reset.
- `enable`  in  1  start request; sampled only while `ready`.
- `mulDivType`  in  3  `MulDivType` command: Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu.
- `srcIntRegValue1`  in  32  rs1 operand (multiplicand / dividend).
- `srcIntRegValue2`  in  32  rs2 operand (multiplier / divisor).
- `flush`  in  1  abort the in-flight operation.
- `ready`  out  1  high in Idle.
- `done`  out  1  high for exactly one cycle (Done state).
- `result`  out  32  final value; valid while `done`, held until the next start.

## Operation
- States: Idle, Mul, Div, Done. `ready = (state == Idle)`, `done = (state == Done)`.
- Idle + `enable`: latch the command, the operand signs and the absolute magnitudes. Load the counter with 31.
  - Mul/Mulh/Mulhsu/Mulhu go to Mul.
  - Div/Divu/Rem/Remu go to Div, except for the special cases below.
- Sign rules:
  - Mulh: signed x signed.
  - Mulhsu: signed rs1 x unsigned rs2.
  - Mulhu, Divu, Remu: unsigned.
  - Mul: low 32 bits; signedness is irrelevant.
  - Div/Rem: signed.
- Mul datapath:
  - 64-bit accumulator. Each cycle, add (multiplicand << i) when multiplier bit i is set.
  - After 32 iterations, negate the 64-bit product if exactly one signed operand is negative.
  - Mul returns bits [31:0]; the high variants return [63:32].
- Div datapath:
  - Restoring division, one quotient bit per cycle, 33-bit partial remainder.
  - Quotient is negated if the signs differ (Div). Remainder takes the sign of the dividend (Rem).
- Special cases, resolved in Idle with the result registered directly and a jump to Done:
  - Divisor 0: Div/Divu return 0xFFFFFFFF; Rem/Remu return rs1.
  - Div with 0x80000000 / 0xFFFFFFFF: returns 0x80000000. Rem with the same operands returns 0.
- Mul/Div: when the counter reaches 0, register `result` and go to Done. Done goes to Idle unconditionally.
- `flush` in any state: Idle on the next edge; `result` is not updated.
  - `flush` has priority over a simultaneous `enable`.
  - `done` is not masked during the flush cycle itself.
- `enable` while not `ready` is ignored, with no queueing.
- Operand inputs are don't-care after the accept edge.

## Timing
- Reset values: state Idle, `ready` 1, `done` 0, `result` 0, counter 0, accumulators 0.
- Reset asserted mid-operation returns to Idle immediately; no `done` is produced.
- Accept edge = cycle 0.
- Iterative Mul/Div: 32 iteration cycles; `done` is high in cycle 33 and `ready` is high in cycle 34.
- Special-case divide: `done` in cycle 1.
- Back-to-back throughput: one operation per 34 cycles (iterative) or per 2 cycles (special case / fast mul).
- `result` is stable from the `done` cycle until the next accept edge.

## Configuration
- `RAFI_MULDIV_FAST_MUL_EN` defined:
  - Mul-class commands compute a combinational 33x33 signed product in Idle, register it, and go directly to Done.
  - Latency is 1 (`done` in cycle 1); the Mul state is unused.
- Undefined: the iterative shift-add path above, latency 33.
- The divide path is identical in both builds.

## Test plan
- Reset check: assert `rstN` low mid-division at cycle 10, then release → `ready` 1, `done` never pulses, `result` 0.
- Signed multiply: Mulh 0xFFFFFFFE x 0x00000003 → `result` 0xFFFFFFFF. Mul with the same operands → 0xFFFFFFFA. `done` at cycle 33 (cycle 1 with `RAFI_MULDIV_FAST_MUL_EN`).
- Mixed-sign multiply: Mulhsu 0xFFFFFFFF x 0xFFFFFFFF → 0xFFFFFFFF. Mulhu with the same operands → 0xFFFFFFFE.
- Signed divide/remainder: Div -7 / 2 → 0xFFFFFFFD. Rem -7 / 2 → 0xFFFFFFFF. Divu 100 / 7 → 14. Remu 100 / 7 → 2. `done` at cycle 33.
- Divide special cases:
  - Div 5 / 0 → 0xFFFFFFFF; Rem 5 / 0 → 5.
  - Div 0x80000000 / 0xFFFFFFFF → 0x80000000; Rem with the same operands → 0.
  - All complete with `done` at cycle 1.
- Flush and handshake:
  - `flush` at cycle 5 of a Divu → Idle at cycle 6, no `done`, `result` unchanged.
  - `enable` pulsed at cycle 10 of a Div is ignored.
  - `flush` together with `enable` in Idle → no operation starts.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide execution unit.
//
// Accepts one command while idle, then runs a shift-add multiplier or a
// restoring divider, one bit per cycle. Divide-by-zero and signed overflow
// are resolved at accept time and reach Done one cycle later.
//
// Optional build macro:
//   RAFI_MULDIV_FAST_MUL_EN - multiply-class commands use a combinational
//                             33x33 signed product and finish in one cycle.
//
// Ports:
//   clk             clock, rising edge
//   rstN            asynchronous active-low reset
//   enable          start request, sampled only while ready
//   mulDivType      command: Mul, Mulh, Mulhsu, Mulhu, Div, Divu, Rem, Remu
//   srcIntRegValue1 rs1 (multiplicand / dividend)
//   srcIntRegValue2 rs2 (multiplier / divisor)
//   flush           abort the in-flight operation
//   ready           high in Idle
//   done            one-cycle completion pulse
//   result          final value, held until the next accept
module mul_div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            enable,
  input  logic [2:0]      mulDivType,
  input  logic [XLEN-1:0] srcIntRegValue1,
  input  logic [XLEN-1:0] srcIntRegValue2,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mulDivOp_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e               stateQ;
  mulDivOp_e            opQ;
  logic [CntW-1:0]      counterQ;
  logic                 negResQ;   // negate product / quotient at the end
  logic                 negRemQ;   // negate remainder (dividend was negative)
  logic [2*XLEN-1:0]    accQ;
  logic [2*XLEN-1:0]    mcandQ;
  logic [XLEN-1:0]      mplrQ;
  logic [XLEN-1:0]      remQ;
  logic [XLEN-1:0]      dvdQ;      // shifts out dividend bits, shifts in quotient bits
  logic [XLEN-1:0]      divisorQ;
  logic [XLEN-1:0]      resultQ;

  // Accept-time decode
  mulDivOp_e       cmd;
  logic            isMulCmd, isRemCmd;
  logic            src1Signed, src2Signed;
  logic            neg1, neg2;
  logic [XLEN-1:0] abs1, abs2;
  logic            divByZero, divOverflow;

  assign cmd        = mulDivOp_e'(mulDivType);
  assign isMulCmd   = ~mulDivType[2];
  assign isRemCmd   = mulDivType[1];
  assign src1Signed = (cmd == OpMulh) || (cmd == OpMulhsu) || (cmd == OpDiv) || (cmd == OpRem);
  assign src2Signed = (cmd == OpMulh) || (cmd == OpDiv) || (cmd == OpRem);
  assign neg1       = src1Signed & srcIntRegValue1[XLEN-1];
  assign neg2       = src2Signed & srcIntRegValue2[XLEN-1];
  // Most-negative value maps to itself, which is the correct unsigned magnitude.
  assign abs1       = neg1 ? -srcIntRegValue1 : srcIntRegValue1;
  assign abs2       = neg2 ? -srcIntRegValue2 : srcIntRegValue2;
  assign divByZero  = (srcIntRegValue2 == '0);
  assign divOverflow = src1Signed && src2Signed &&
                       (srcIntRegValue1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                       (srcIntRegValue2 == '1);

  // Multiply step; the final step also produces the signed result.
  logic [2*XLEN-1:0] accNext, prodFinal;
  logic [XLEN-1:0]   mulResult;

  assign accNext   = accQ + (mplrQ[0] ? mcandQ : '0);
  assign prodFinal = negResQ ? -accNext : accNext;
  assign mulResult = (opQ == OpMul) ? prodFinal[XLEN-1:0] : prodFinal[2*XLEN-1:XLEN];

  // Restoring divide step: 33-bit partial remainder compared with the divisor.
  logic [XLEN:0]   remShift;
  logic            qBit;
  logic [XLEN-1:0] remNext, dvdNext, quotFinal, remFinal, divResult;

  assign remShift  = {remQ, dvdQ[XLEN-1]};
  assign qBit      = (remShift >= {1'b0, divisorQ});
  // When qBit is set the true difference is below the divisor, so it fits XLEN bits.
  assign remNext   = qBit ? (remShift[XLEN-1:0] - divisorQ) : remShift[XLEN-1:0];
  assign dvdNext   = {dvdQ[XLEN-2:0], qBit};
  assign quotFinal = negResQ ? -dvdNext : dvdNext;
  assign remFinal  = negRemQ ? -remNext : remNext;
  assign divResult = opQ[1] ? remFinal : quotFinal;

`ifdef RAFI_MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fastA, fastB;
  logic signed [2*XLEN+1:0] fastProd;

  assign fastA    = $signed({neg1, srcIntRegValue1});
  assign fastB    = $signed({neg2, srcIntRegValue2});
  assign fastProd = fastA * fastB;
`endif

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateQ   <= StIdle;
      opQ      <= OpMul;
      counterQ <= '0;
      negResQ  <= 1'b0;
      negRemQ  <= 1'b0;
      accQ     <= '0;
      mcandQ   <= '0;
      mplrQ    <= '0;
      remQ     <= '0;
      dvdQ     <= '0;
      divisorQ <= '0;
      resultQ  <= '0;
    end else if (flush) begin
      // Abort wins over everything, including a same-cycle enable.
      stateQ <= StIdle;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (enable) begin
            opQ      <= cmd;
            counterQ <= CntW'(XLEN - 1);
            negResQ  <= neg1 ^ neg2;
            negRemQ  <= neg1;
            if (isMulCmd) begin
`ifdef RAFI_MULDIV_FAST_MUL_EN
              resultQ <= (cmd == OpMul) ? fastProd[XLEN-1:0] : fastProd[2*XLEN-1:XLEN];
              stateQ  <= StDone;
`else
              accQ   <= '0;
              mcandQ <= {{XLEN{1'b0}}, abs1};
              mplrQ  <= abs2;
              stateQ <= StMul;
`endif
            end else if (divByZero) begin
              resultQ <= isRemCmd ? srcIntRegValue1 : '1;
              stateQ  <= StDone;
            end else if (divOverflow) begin
              resultQ <= isRemCmd ? '0 : srcIntRegValue1;
              stateQ  <= StDone;
            end else begin
              remQ     <= '0;
              dvdQ     <= abs1;
              divisorQ <= abs2;
              stateQ   <= StDiv;
            end
          end
        end
        StMul: begin
          accQ     <= accNext;
          mcandQ   <= mcandQ << 1;
          mplrQ    <= mplrQ >> 1;
          counterQ <= counterQ - CntW'(1);
          if (counterQ == '0) begin
            resultQ <= mulResult;
            stateQ  <= StDone;
          end
        end
        StDiv: begin
          remQ     <= remNext;
          dvdQ     <= dvdNext;
          counterQ <= counterQ - CntW'(1);
          if (counterQ == '0) begin
            resultQ <= divResult;
            stateQ  <= StDone;
          end
        end
        StDone:  stateQ <= StIdle;
        default: stateQ <= StIdle;
      endcase
    end
  end

  assign ready  = (stateQ == StIdle);
  assign done   = (stateQ == StDone);
  assign result = resultQ;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, hand-written
// flush/reset/handshake sequences, and random commands against an
// arithmetic reference model. Honours RAFI_MULDIV_FAST_MUL_EN for latency.
module tb_mul_div_unit;

`ifdef RAFI_MULDIV_FAST_MUL_EN
  localparam int MulLat = 1;
`else
  localparam int MulLat = 33;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        enable;
  logic [2:0]  mulDivType;
  logic [31:0] src1, src2;
  logic        flush;
  logic        ready, done;
  logic [31:0] result;

  int nCompared   = 0;
  int nMismatched = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk             (clk),
    .rstN            (rstN),
    .enable          (enable),
    .mulDivType      (mulDivType),
    .srcIntRegValue1 (src1),
    .srcIntRegValue2 (src2),
    .flush           (flush),
    .ready           (ready),
    .done            (done),
    .result          (result)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference model from the instruction semantics, using 64-bit arithmetic.
  function automatic logic [31:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    p = '0;
    case (op)
      3'd0: begin p = sa * sb; return p[31:0];  end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFFFFFF;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFFFFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int refLatency(input logic [2:0] op, input logic [31:0] a,
                                    input logic [31:0] b);
    if (op < 3'd4) return MulLat;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h80000000;
      2:       return 32'hFFFFFFFF;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called at a negedge with the unit idle; returns at the negedge of the done cycle.
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    lat = -1;
    res = 'x;
    enable = 1'b1;
    mulDivType = op;
    src1 = a;
    src2 = b;
    @(posedge clk);
    #1;
    enable = 1'b0;
    mulDivType = 3'($urandom);
    src1 = $urandom;
    src2 = $urandom;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc;
        res = result;
        break;
      end
    end
  endtask

  task automatic countDone(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] res, prevRes;
  int          lat, pulses;

  initial begin
    vecs.push_back('{"mulh_neg2x3",     3'd1, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, MulLat});
    vecs.push_back('{"mul_neg2x3",      3'd0, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFA, MulLat});
    vecs.push_back('{"mulhsu_m1xmax",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MulLat});
    vecs.push_back('{"mulhu_maxxmax",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MulLat});
    vecs.push_back('{"mulh_minxmin",    3'd1, 32'h80000000, 32'h80000000, 32'h40000000, MulLat});
    vecs.push_back('{"div_m7_2",        3'd4, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33});
    vecs.push_back('{"rem_m7_2",        3'd6, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33});
    vecs.push_back('{"divu_100_7",      3'd5, 32'd100, 32'd7, 32'd14, 33});
    vecs.push_back('{"remu_100_7",      3'd7, 32'd100, 32'd7, 32'd2, 33});
    vecs.push_back('{"div_5_0",         3'd4, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    vecs.push_back('{"rem_5_0",         3'd6, 32'd5, 32'd0, 32'd5, 1});
    vecs.push_back('{"divu_5_0",        3'd5, 32'd5, 32'd0, 32'hFFFFFFFF, 1});
    vecs.push_back('{"remu_5_0",        3'd7, 32'd5, 32'd0, 32'd5, 1});
    vecs.push_back('{"div_ovf",         3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1});
    vecs.push_back('{"rem_ovf",         3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1});
    vecs.push_back('{"divu_min_max",    3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h0, 33});
    vecs.push_back('{"remu_min_max",    3'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 33});

    rstN = 1'b0;
    enable = 1'b0;
    flush = 1'b0;
    mulDivType = 3'd0;
    src1 = '0;
    src2 = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'h0);
    rstN = 1'b1;
    @(negedge clk);

    // Directed vector table
    foreach (vecs[i]) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
      check({vecs[i].name, "_ready_after"}, 32'(ready), 32'd1);
      check({vecs[i].name, "_held"}, result, vecs[i].exp);
    end

    // Flush at cycle 5 of a Divu: back to Idle at cycle 6, no done, result held
    prevRes = result;
    enable = 1'b1; mulDivType = 3'd5; src1 = 32'd1000; src2 = 32'd3;
    @(posedge clk); #1;
    enable = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready_c6", 32'(ready), 32'd1);
    check("flush_result_held", result, prevRes);
    countDone(40, lat);
    check("flush_no_done", 32'(pulses + lat), 32'd0);
    check("flush_result_still", result, prevRes);

    // Enable pulsed at cycle 10 of a Div is ignored
    enable = 1'b1; mulDivType = 3'd4; src1 = 32'hFFFFFFF9; src2 = 32'd2;
    @(posedge clk); #1;
    enable = 1'b0;
    lat = -1;
    res = 'x;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      enable = (cyc == 10);
      mulDivType = 3'd0; src1 = 32'd3; src2 = 32'd3;
      if (done) begin
        lat = cyc;
        res = result;
        break;
      end
    end
    enable = 1'b0;
    check("ign_enable_result", res, 32'hFFFFFFFD);
    check("ign_enable_latency", 32'(lat), 32'd33);
    countDone(40, pulses);
    check("ign_enable_no_extra", 32'(pulses), 32'd0);
    check("ign_enable_result_held", result, 32'hFFFFFFFD);

    // Flush and enable together in Idle: nothing starts
    prevRes = result;
    enable = 1'b1; flush = 1'b1; mulDivType = 3'd5; src1 = 32'd5; src2 = 32'd0;
    @(posedge clk); #1;
    enable = 1'b0; flush = 1'b0;
    countDone(40, pulses);
    check("flush_enable_no_done", 32'(pulses), 32'd0);
    check("flush_enable_ready", 32'(ready), 32'd1);
    check("flush_enable_result", result, prevRes);

    // Reset mid-division at cycle 10
    enable = 1'b1; mulDivType = 3'd4; src1 = 32'd100; src2 = 32'd7;
    @(posedge clk); #1;
    enable = 1'b0;
    pulses = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rstN = 1'b0;
    #1;
    check("rst_mid_ready", 32'(ready), 32'd1);
    check("rst_mid_result", result, 32'h0);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    countDone(40, lat);
    check("rst_mid_no_done", 32'(pulses + lat), 32'd0);
    check("rst_mid_ready_after", 32'(ready), 32'd1);
    check("rst_mid_result_after", result, 32'h0);

    // Random commands against the reference model
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom);
      a = randOperand();
      b = randOperand();
      runOp(op, a, b, res, lat);
      if (res !== refModel(op, a, b) || lat != refLatency(op, a, b))
        $display("  random #%0d op=%0d a=%h b=%h", n, op, a, b);
      check("rand_result", res, refModel(op, a, b));
      check("rand_latency", 32'(lat), 32'(refLatency(op, a, b)));
      @(negedge clk);
      check("rand_ready_after", 32'(ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
